// File: rtl/lpif_tx_concat_gen.sv
// lpif_tx_concat_gen: buffers upstream words and slices them across PHY channels,
// inserting a generated strobe and a periodic marker bit in every channel.
module lpif_tx_concat_gen #(
  parameter int NUM_CH          = 2,
  parameter int CH_WIDTH        = 40,
  parameter int STB_LOC         = 1,
  parameter int MRK_LOC         = 39,
  parameter int MRK_PERIOD_GEN1 = 1,
  parameter int MRK_PERIOD_GEN2 = 4,
  parameter int STB_PERIOD      = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int REG_PHY         = 0
) (
  input  logic                                 clk_wr,
  input  logic                                 rst_wr_n,
  input  logic                                 tx_online,
  input  logic                                 m_gen2_mode,
  input  logic                                 stb_persistent,
  input  logic                                 tx_stb_userbit,
  input  logic [NUM_CH*(CH_WIDTH-2)-1:0]       in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [NUM_CH*CH_WIDTH-1:0]           tx_phy,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_level,
  output logic                                 underflow
);
  localparam int DW = CH_WIDTH - 2;
  localparam int IW = NUM_CH * DW;
  localparam int TW = NUM_CH * CH_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int MRK_MAX = MRK_PERIOD_GEN2 > MRK_PERIOD_GEN1 ? MRK_PERIOD_GEN2 : MRK_PERIOD_GEN1;
  localparam int MW = MRK_MAX > 1 ? $clog2(MRK_MAX) : 1;
  localparam int SW = STB_PERIOD > 1 ? $clog2(STB_PERIOD) : 1;

  logic [IW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [MW-1:0] mrk_cnt_q, mrk_cnt_d, mrk_last;
  logic [SW-1:0] stb_cnt_q, stb_cnt_d;
  logic          mode_q, underflow_q, underflow_d;
  logic          full, empty, push, pop, mrk, stb;
  logic [IW-1:0] word;
  logic [TW-1:0] frame, phy_q, phy_d;

  always_comb begin
    full        = level_q == LW'(FIFO_DEPTH);
    empty       = level_q == '0;
    push        = in_valid && !full;
    pop         = tx_online && !empty;
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d     = level_q + LW'(push) - LW'(pop);
    mrk_last    = m_gen2_mode ? MW'(MRK_PERIOD_GEN2 - 1) : MW'(MRK_PERIOD_GEN1 - 1);
    mrk         = mrk_cnt_q == mrk_last;
    // a mode change restarts the marker period on the following beat
    mrk_cnt_d   = !tx_online || mode_q != m_gen2_mode || mrk ? '0 : mrk_cnt_q + 1'b1;
    stb         = stb_persistent ? tx_stb_userbit : stb_cnt_q == '0;
    stb_cnt_d   = !tx_online || stb_cnt_q == SW'(STB_PERIOD - 1) ? '0 : stb_cnt_q + 1'b1;
    underflow_d = underflow_q || (tx_online && empty);
    word        = empty ? '0 : mem_q[rd_ptr_q];
    phy_d       = tx_online ? frame : '0;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar b = 0; b < CH_WIDTH; b++) begin : g_bit
      if (b == STB_LOC) begin : g_stb
        assign frame[c*CH_WIDTH+b] = stb;
      end else if (b == MRK_LOC) begin : g_mrk
        assign frame[c*CH_WIDTH+b] = mrk;
      end else begin : g_dat
        assign frame[c*CH_WIDTH+b] = word[c*DW + b - (b > STB_LOC ? 1 : 0) - (b > MRK_LOC ? 1 : 0)];
      end
    end
  end

  always_ff @(posedge clk_wr) if (push) mem_q[wr_ptr_q] <= in_data;

  always_ff @(posedge clk_wr or negedge rst_wr_n)
    if (!rst_wr_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      mrk_cnt_q   <= '0;
      stb_cnt_q   <= '0;
      mode_q      <= 1'b0;
      underflow_q <= 1'b0;
      phy_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      mrk_cnt_q   <= mrk_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      mode_q      <= m_gen2_mode;
      underflow_q <= underflow_d;
      phy_q       <= phy_d;
    end

  if (REG_PHY != 0) begin : g_reg
    logic [TW-1:0] phy2_q;
    always_ff @(posedge clk_wr or negedge rst_wr_n)
      if (!rst_wr_n) phy2_q <= '0;
      else phy2_q <= phy_q;
    assign tx_phy = phy2_q;
  end else begin : g_noreg
    assign tx_phy = phy_q;
  end

  assign in_ready   = !full;
  assign fifo_level = level_q;
  assign underflow  = underflow_q;
endmodule

// File: tb/tb_lpif_tx_concat_gen.sv
// tb_lpif_tx_concat_gen: directed table plus hand sequences for the TX concatenator
// at default parameters (2 channels x 40 bits, strobe bit 1, marker bit 39).
module tb_lpif_tx_concat_gen;
  logic        clk = 1'b0;
  logic        rst_wr_n = 1'b0;
  logic        tx_online = 1'b0, m_gen2_mode = 1'b0, stb_persistent = 1'b1, tx_stb_userbit = 1'b1;
  logic [75:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [79:0] tx_phy;
  logic [2:0]  fifo_level;
  logic        underflow;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  lpif_tx_concat_gen dut (
    .clk_wr(clk), .rst_wr_n(rst_wr_n), .tx_online(tx_online), .m_gen2_mode(m_gen2_mode),
    .stb_persistent(stb_persistent), .tx_stb_userbit(tx_stb_userbit), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .tx_phy(tx_phy), .fifo_level(fifo_level),
    .underflow(underflow)
  );

  typedef struct {
    bit          online, valid, ubit;
    logic [75:0] data;
    logic [79:0] exp_phy;
    bit          exp_ready;
    int          exp_level;
    bit          exp_uf;
  } vec_t;

  // data bits fill positions 0,2..38 of each channel; 1 is strobe, 39 is marker
  function automatic logic [79:0] frame(input logic [75:0] w, input bit s, input bit m);
    logic [79:0] f;
    f = '0;
    for (int c = 0; c < 2; c++) begin
      f[c*40+1]  = s;
      f[c*40+39] = m;
      for (int k = 0; k < 38; k++) f[c*40 + (k == 0 ? 0 : k + 1)] = w[c*38+k];
    end
    return f;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [75:0] W38 = 76'h40_0000_0000;
  localparam logic [75:0] WA  = 76'hF0F0F_0F0F0_F0F0F_0F0F;
  localparam logic [75:0] WB  = 76'h12345_6789A_BCDEF_0123;
  localparam logic [75:0] WC  = 76'hDEAD_BEEF;
  localparam logic [75:0] WD  = 76'h3;
  localparam logic [75:0] WE  = 76'h80000_00000_00000_0000;
  localparam logic [75:0] WF  = 76'h00000_00004_00000_0001;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{0, 1, 1, 76'h1, '0, 1, 1, 0};
    vecs[1]  = '{0, 1, 1, W38, '0, 1, 2, 0};
    vecs[2]  = '{0, 1, 1, WA, '0, 1, 3, 0};
    vecs[3]  = '{0, 1, 1, WB, '0, 0, 4, 0};
    vecs[4]  = '{0, 1, 1, WC, '0, 0, 4, 0};
    vecs[5]  = '{1, 1, 1, WC, frame(76'h1, 1, 1), 1, 3, 0};
    vecs[6]  = '{1, 0, 1, '0, frame(W38, 1, 1), 1, 2, 0};
    vecs[7]  = '{1, 0, 1, '0, frame(WA, 1, 1), 1, 1, 0};
    vecs[8]  = '{1, 0, 1, '0, frame(WB, 1, 1), 1, 0, 0};
    vecs[9]  = '{1, 1, 1, WD, frame('0, 1, 1), 1, 1, 1};
    vecs[10] = '{1, 0, 0, '0, frame(WD, 0, 1), 1, 0, 1};
    vecs[11] = '{0, 0, 1, '0, '0, 1, 0, 1};
    vecs[12] = '{1, 1, 1, WE, frame('0, 1, 1), 1, 1, 1};
    vecs[13] = '{1, 1, 1, WF, frame(WE, 1, 1), 1, 1, 1};
    vecs[14] = '{0, 0, 1, '0, '0, 1, 1, 1};
    vecs[15] = '{1, 0, 1, '0, frame(WF, 1, 1), 1, 0, 1};

    repeat (2) @(negedge clk);
    chk("reset_phy", tx_phy, '0);
    chk("reset_ready", 80'(in_ready), 80'd1);
    chk("reset_level", 80'(fifo_level), 80'd0);
    chk("reset_uf", 80'(underflow), 80'd0);
    rst_wr_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      tx_online = vecs[i].online;
      in_valid = vecs[i].valid;
      tx_stb_userbit = vecs[i].ubit;
      in_data = vecs[i].data;
      step();
      chk($sformatf("row%0d_phy", i), tx_phy, vecs[i].exp_phy);
      chk($sformatf("row%0d_ready", i), 80'(in_ready), 80'(vecs[i].exp_ready));
      chk($sformatf("row%0d_level", i), 80'(fifo_level), 80'(vecs[i].exp_level));
      chk($sformatf("row%0d_uf", i), 80'(underflow), 80'(vecs[i].exp_uf));
    end

    in_valid = 1'b0;
    tx_stb_userbit = 1'b0;
    tx_online = 1'b0;
    m_gen2_mode = 1'b1;
    step();
    step();
    tx_online = 1'b1;
    for (int b = 0; b < 12; b++) begin
      step();
      chk($sformatf("gen2_mrk_b%0d", b), tx_phy, frame('0, 0, b % 4 == 3));
    end

    tx_online = 1'b0;
    m_gen2_mode = 1'b0;
    step();
    tx_online = 1'b1;
    for (int b = 0; b < 14; b++) begin
      if (b == 5) m_gen2_mode = 1'b1;
      step();
      chk($sformatf("toggle_mrk_b%0d", b), tx_phy, frame('0, 0, b < 5 || (b >= 6 && (b - 6) % 4 == 3)));
    end

    tx_online = 1'b0;
    m_gen2_mode = 1'b0;
    stb_persistent = 1'b0;
    step();
    tx_online = 1'b1;
    for (int b = 0; b < 20; b++) begin
      step();
      chk($sformatf("pulse_stb_b%0d", b), tx_phy, frame('0, b % 8 == 0, 1));
    end
    stb_persistent = 1'b1;
    tx_stb_userbit = 1'b1;
    for (int b = 0; b < 3; b++) begin
      step();
      chk($sformatf("pers_stb_b%0d", b), tx_phy, frame('0, 1, 1));
    end

    tx_online = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = WA ^ 76'(i);
      step();
    end
    chk("fill_level", 80'(fifo_level), 80'd4);
    chk("fill_ready", 80'(in_ready), 80'd0);
    in_valid = 1'b0;
    tx_online = 1'b1;
    step();
    chk("pre_rst_phy", tx_phy, frame(WA, 1, 1));
    chk("pre_rst_level", 80'(fifo_level), 80'd3);
    #2 rst_wr_n = 1'b0;
    #1;
    chk("async_rst_phy", tx_phy, '0);
    chk("async_rst_level", 80'(fifo_level), 80'd0);
    chk("async_rst_uf", 80'(underflow), 80'd0);
    chk("async_rst_ready", 80'(in_ready), 80'd1);
    @(negedge clk);
    rst_wr_n = 1'b1;
    step();
    chk("post_rst_phy", tx_phy, frame('0, 1, 1));
    chk("post_rst_level", 80'(fifo_level), 80'd0);
    chk("post_rst_uf", 80'(underflow), 80'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lpif_tx_concat_gen.md
Name: lpif_tx_concat_gen

Overview:
- Parametrised TX-side LPIF concatenator for NUM_CH PHY channels of CH_WIDTH bits.
- Buffers upstream words in a small FIFO with a valid/ready handshake.
- Slices each word across channels and inserts a generated strobe and a periodic marker at fixed bit locations.
- Sits between the logic-link TX upstream interface and the AIB PHY TX lanes; paces the PHY at one word per beat while tx_online.

Parameters:
- NUM_CH, 2, number of PHY channels (1..8).
- CH_WIDTH, 40, bits per PHY channel.
- STB_LOC, 1, strobe bit position within each channel.
- MRK_LOC, 39, marker bit position within each channel; must differ from STB_LOC.
- MRK_PERIOD_GEN1, 1, beats per marker period when m_gen2_mode=0.
- MRK_PERIOD_GEN2, 4, beats per marker period when m_gen2_mode=1.
- STB_PERIOD, 8, beats between strobe pulses in pulsed mode.
- FIFO_DEPTH, 4, entries; power of 2, at least 2.
- REG_PHY, 0, if 1, adds one extra output flop stage on tx_phy.

Ports:
- clk_wr  in  1  TX write clock.
- rst_wr_n  in  1  reset, asynchronous, active-low.
- tx_online  in  1  PHY link up; enables popping and beat counting.
- m_gen2_mode  in  1  selects the marker period.
- stb_persistent  in  1  1 = strobe follows tx_stb_userbit on every beat; 0 = pulsed strobe.
- tx_stb_userbit  in  1  strobe value used in persistent mode.
- in_data  in  NUM_CH*(CH_WIDTH-2)  upstream word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO not full.
- tx_phy  out  NUM_CH*CH_WIDTH  channel c occupies bits [c*CH_WIDTH +: CH_WIDTH].
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- underflow  out  1  sticky: a beat was sent with the FIFO empty.

Behaviour:
- Reset values: tx_phy=0, in_ready=1, fifo_level=0, underflow=0, all counters 0, FIFO empty.
- DATA_W = CH_WIDTH-2.
  - in_data bit c*DATA_W+k maps to the k-th non-STB/non-MRK bit of channel c, ascending bit order.
  - Example, NUM_CH=2, CH_WIDTH=40: word bit 0 → ch0[0]; bit 1 → ch0[2]; bit 37 → ch0[38]; bit 38 → ch1[0].
- Push rule:
  - Push occurs on in_valid && in_ready; in_ready = !full, taken from registered state.
  - When full, in_ready stays low even if a pop happens in the same cycle (no pass-through).
- Pop rule:
  - Pop occurs on tx_online && !empty, using registered empty. No fall-through.
  - Simultaneous push and pop: level is unchanged, and both pointers advance modulo FIFO_DEPTH.
- Output register: tx_phy is updated every clk_wr edge.
- Latency:
  - A word pushed in cycle N (FIFO otherwise empty, online) appears on tx_phy in cycle N+2.
  - With REG_PHY=1 it appears in cycle N+3.
- Offline (tx_online=0):
  - The tx_phy register loads all-zero.
  - No pop; FIFO contents are retained.
  - mrk_cnt and stb_cnt are held at 0.
- Marker:
  - P = m_gen2_mode ? MRK_PERIOD_GEN2 : MRK_PERIOD_GEN1.
  - mrk_cnt counts 0..P-1 on each online beat and wraps to 0.
  - Marker bit is 1 in every channel on the beat where mrk_cnt==P-1.
  - P=1 gives a persistent marker.
  - Any change of m_gen2_mode (detected against a registered copy) forces mrk_cnt to 0 on the next beat.
- Strobe:
  - Persistent mode: strobe bit = tx_stb_userbit on every online beat, all channels.
  - Pulsed mode: stb_cnt counts 0..STB_PERIOD-1; strobe = 1 on the beat where stb_cnt==0. This includes the first beat after tx_online rises.
- Underflow:
  - An online beat with the FIFO empty emits zero data fields, with strobe and marker still inserted.
  - It sets underflow; underflow clears only on reset.
- Mid-operation reset: all state returns to reset values asynchronously; FIFO contents are discarded.
- tx_online falling mid-stream: the popped word already in the output register is sent; the next beat is zero. Popping resumes when tx_online returns.

Test Plan:
- Defaults, online, push 0x1 then 0x4000000000 (bit 38) → tx_phy ch0[0]=1 at N+2; next beat ch1[0]=1; marker bits 39 and 79 =1 every beat (P=1).
- m_gen2_mode=1, online, continuous stream → marker=1 on beats 3,7,11,…. Toggling mode at beat 5 → next marker on beat 5+4=9 relative to the restart.
- stb_persistent=0, online for 20 beats → strobe bits 1 and 41 high on beats 0, 8, 16 only. stb_persistent=1 with tx_stb_userbit=1 → strobe high every beat.
- tx_online=0, push 4 words → in_ready=0 after the 4th, fifo_level=4, tx_phy=0. Raise online → 4 words drain in order and level reaches 0.
- Online with an empty FIFO for 1 beat → tx_phy data fields 0, strobe/marker present, underflow=1 and held.
- Assert rst_wr_n low with fifo_level=3 → immediately tx_phy=0, level=0, underflow=0, in_ready=1.
